// File: rtl/alu_pkg.sv
// Shared opcode constants and issue-FSM state encoding for the ALU issue stage.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 reads as zero.
module alu_regfile #(
    parameter int REGS   = 8,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata
);

    logic [WIDTH-1:0] mem_q [REGS];
    logic [WIDTH-1:0] mem_d [REGS];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/alu_structural.sv
// Purely combinational ALU; overflow is the adder carry-out (add and sub), zero flags a zero result.
module alu_structural
    import alu_pkg::*;
#(
    parameter int OPERATION = 3,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 3
) (
    input  logic [OPERATION-1:0] operation,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [SHIFT-1:0]     shamt,
    input  logic                 carry_in,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow,
    output logic                 zero
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry_in};
    assign diff = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (operation)
            OPERATION'(OP_AND): result = x & y;
            OPERATION'(OP_OR):  result = x | y;
            OPERATION'(OP_XOR): result = x ^ y;
            OPERATION'(OP_ADD): {overflow, result} = sum;
            OPERATION'(OP_SUB): {overflow, result} = diff;
            OPERATION'(OP_SLL): result = x << shamt;
            OPERATION'(OP_SRL): result = x >> shamt;
            OPERATION'(OP_SLT): result[0] = ($signed(x) < $signed(y));
            default:            result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/execute/write-back sequencer wrapped around the combinational ALU.
// Each command takes three cycles: accept (IDLE), ALU evaluation (EXEC), retire (WB).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int OPERATION = 3,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 3,
    parameter int REGS      = 8,
    parameter int ADDR_W    = $clog2(REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OPERATION-1:0] cmd_op,
    input  logic [ADDR_W-1:0]    cmd_rd,
    input  logic [ADDR_W-1:0]    cmd_rs1,
    input  logic [ADDR_W-1:0]    cmd_rs2,
    input  logic [SHIFT-1:0]     cmd_shamt,
    input  logic                 cmd_use_carry,
    output logic [OPERATION-1:0] alu_operation,
    output logic [WIDTH-1:0]     alu_x,
    output logic [WIDTH-1:0]     alu_y,
    output logic [SHIFT-1:0]     alu_shamt,
    output logic                 alu_carry_in,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_overflow,
    input  logic                 alu_zero,
    output logic                 done_valid,
    output logic [WIDTH-1:0]     done_data,
    output logic [ADDR_W-1:0]    done_rd,
    output logic                 flag_zero,
    output logic                 flag_carry
);

    state_t               state_q, state_d;
    logic [OPERATION-1:0] op_q, op_d;
    logic [ADDR_W-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [SHIFT-1:0]     shamt_q, shamt_d;
    logic                 cin_q, cin_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 zro_q, zro_d;
    logic                 flag_zero_q, flag_zero_d;
    logic                 flag_carry_q, flag_carry_d;

    logic [WIDTH-1:0]     rs1_data;
    logic [WIDTH-1:0]     rs2_data;
    logic                 rf_we;

    alu_regfile #(
        .REGS  (REGS),
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr_a(cmd_rs1),
        .rdata_a(rs1_data),
        .raddr_b(cmd_rs2),
        .rdata_b(rs2_data),
        .we     (rf_we),
        .waddr  (rd_q),
        .wdata  (res_q)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        x_d          = x_q;
        y_d          = y_q;
        shamt_d      = shamt_q;
        cin_d        = cin_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        zro_d        = zro_q;
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        cmd_ready    = 1'b0;
        rf_we        = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    x_d     = rs1_data;
                    y_d     = rs2_data;
                    shamt_d = cmd_shamt;
                    cin_d   = cmd_use_carry & flag_carry_q;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                ovf_d   = alu_overflow;
                zro_d   = alu_zero;
                state_d = WB;
            end
            WB: begin
                rf_we       = 1'b1;
                flag_zero_d = zro_q;
                // Only add produces a carry that later commands may chain on.
                if (op_q == OPERATION'(OP_ADD)) begin
                    flag_carry_d = ovf_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            shamt_q      <= '0;
            cin_q        <= 1'b0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            zro_q        <= 1'b0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            x_q          <= x_d;
            y_q          <= y_d;
            shamt_q      <= shamt_d;
            cin_q        <= cin_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            zro_q        <= zro_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
        end
    end

    assign alu_operation = op_q;
    assign alu_x         = x_q;
    assign alu_y         = y_q;
    assign alu_shamt     = shamt_q;
    assign alu_carry_in  = cin_q;
    assign done_valid    = (state_q == WB);
    assign done_data     = res_q;
    assign done_rd       = rd_q;
    assign flag_zero     = flag_zero_q;
    assign flag_carry    = flag_carry_q;

endmodule
